uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

UART transmit framer that sits directly downstream of the TX baud-rate tick generator. It accepts one data word per valid/ready handshake and requests bit timing from the tick generator with a one-cycle `tx_start` pulse. It then shifts a complete frame out on `uart_txd`, one bit per `bps_clk` tick: start bit, data LSB-first, optional parity, stop bit(s). When the last stop bit has run its full bit period, it pulses `tx_done` so the tick generator stops counting.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal 5–9.
- `PARITY_MODE`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; legal 1 or 2.
- `clk`  in  1  system clock; one clock domain, shared with the tick generator.
- `rst`  in  1  reset, synchronous, active-high.
- `tx_data`  in  DATA_WIDTH  word to send; sampled on the handshake cycle.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  framer is idle and will accept a word.
- `tx_start`  out  1  one-cycle request to the tick generator to start bit timing.
- `bps_clk`  in  1  one-cycle bit tick from the tick generator.
- `tx_done`  out  1  one-cycle pulse: frame finished, tick generator must stop.
- `uart_txd`  out  1  serial line; idles high.
- `busy`  out  1  high from handshake until the `tx_done` cycle, inclusive.

## Operation
- All outputs are registered.
- Reset values: `uart_txd`=1, `tx_ready`=1, `tx_start`=0, `tx_done`=0, `busy`=0, state=IDLE, bit counter=0.
- FSM states: IDLE, ARM, WAIT_TICK, START, DATA, PARITY, STOP.
- IDLE: `tx_ready`=1.
  - On `tx_valid` & `tx_ready`: latch `tx_data` into the shift register.
  - Compute parity. Odd mode: parity = ~^data. Even mode: parity = ^data.
  - Next state ARM.
- ARM: `tx_start`=1 for exactly this cycle. Next state WAIT_TICK.
- WAIT_TICK: `uart_txd` stays 1.
  - On `bps_clk`: `uart_txd`←0, next state START.
- START: on `bps_clk`: `uart_txd`←shift[0], shift right, counter←1, next state DATA.
- DATA: on `bps_clk`:
  - If counter < DATA_WIDTH: drive next bit, counter++.
  - Else, if PARITY_MODE≠0: drive parity, next state PARITY.
  - Else: drive 1, counter←1, next state STOP.
- PARITY: on `bps_clk`: `uart_txd`←1, counter←1, next state STOP.
- STOP: on `bps_clk`:
  - If counter < STOP_BITS: hold 1, counter++.
  - Else: pulse `tx_done`, next state IDLE.
- `bps_clk` is ignored in IDLE and ARM.
- Counter width is $clog2(DATA_WIDTH+1). The counter never wraps within a frame.
- `tx_data` and `tx_valid` changes while busy have no effect. No word is dropped: `tx_ready`=0 applies back-pressure.
- `rst` asserted mid-frame: the next edge forces all reset values. `tx_done` is not pulsed. A partial frame ends with the line high. The system resets the tick generator on the same `rst`.
- `tx_valid` arriving in the same cycle as a `tx_done` pulse is not accepted, because `tx_ready`=0 in that cycle. It is accepted on the next cycle in IDLE.

## Timing
- Handshake sampled at edge N. `tx_start` is high during cycle N+1 only.
- `uart_txd` changes only on edges where `bps_clk`=1 is sampled. Each bit lasts exactly one tick period.
- First tick: `uart_txd` falls to 0, the start bit.
- Frame length in ticks, including the final tick that ends the stop period: 1 + 1 + DATA_WIDTH + (PARITY_MODE≠0) + STOP_BITS. For 8N1 this is 11 ticks after the handshake.
- `tx_done` rises on the edge that samples the final tick and lasts one cycle.
  - `busy` falls and `tx_ready` rises on the following edge.
- Minimum gap between frames: 1 idle cycle of `tx_ready` plus ARM plus the tick latency.
- Throughput bound: 1 frame per (frame ticks × tick period + 2) cycles.

## Test plan
- 8N1, word 0xA5, bench tick model with period 4 cycles after `tx_start`:
  - `uart_txd` sequence per tick is 0,1,0,1,0,0,1,0,1,1, then high.
  - Exactly one `tx_start` pulse and one `tx_done` pulse.
  - `tx_done` on the 11th tick.
- `PARITY_MODE`=2, word 0x07: parity bit 1. `PARITY_MODE`=1, word 0x07: parity bit 0. Check `STOP_BITS`=2 gives a 2-tick high stop period.
- Back-to-back: `tx_valid` held high with words 0x00 then 0xFF.
  - Second handshake occurs 1 cycle after `tx_done`.
  - `tx_ready`=0 throughout the first frame.
  - Both frames are bit-exact.
- Spurious `bps_clk` pulses in IDLE and in the ARM cycle: `uart_txd` stays 1 and the FSM does not advance.
- `rst` asserted at the 5th data bit:
  - Next edge gives `uart_txd`=1, `tx_ready`=1, `busy`=0, no `tx_done`.
  - A new 0x3C frame afterwards is correct.
- `DATA_WIDTH`=5, word 0x1F, 5N1: 8 ticks per frame, bits 0,1,1,1,1,1,1.

Source files
------------

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer paced by an external baud tick generator
// Emits start, LSB-first data, optional parity and stop bits, one bit per bps_clk tick.
module uart_tx_frame #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_start,
    input  logic                  bps_clk,
    output logic                  tx_done,
    output logic                  uart_txd,
    output logic                  busy
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_TICK,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  parity_q, parity_d;
    logic                  txd_q, txd_d;
    logic                  ready_q, ready_d;
    logic                  start_q, start_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            txd_q    <= 1'b1;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            txd_q    <= txd_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        txd_d    = txd_q;
        ready_d  = ready_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            // Entered with ready low right after tx_done, so ready only rises one edge later.
            S_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (tx_valid && ready_q) begin
                    shift_d  = tx_data;
                    parity_d = (PARITY_MODE == 1) ? ~^tx_data : ^tx_data;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    start_d  = 1'b1;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (bps_clk) begin
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bps_clk) begin
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = CNT_ONE;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bps_clk) begin
                    if (cnt_q < LAST_DATA) begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else if (PARITY_MODE != 0) begin
                        txd_d   = parity_q;
                        state_d = S_PARITY;
                    end else begin
                        txd_d   = 1'b1;
                        cnt_d   = CNT_ONE;
                        state_d = S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bps_clk) begin
                    txd_d   = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bps_clk) begin
                    if (cnt_q < LAST_STOP) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx_ready = ready_q;
    assign tx_start = start_q;
    assign tx_done  = done_q;
    assign uart_txd = txd_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - scoreboard bench for uart_tx_frame across several frame formats
module tb_uart_tx_frame;
    localparam int NI = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_fin    = 0;

    task automatic check(input string name, input int inst, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, req);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : gi
        localparam int DW   = (g == 4) ? 5 : (g == 5) ? 9 : 8;
        localparam int PM   = (g == 1 || g == 5) ? 2 : (g == 2) ? 1 : 0;
        localparam int SB   = (g == 3 || g == 5) ? 2 : 1;
        localparam int FLEN = 1 + DW + ((PM != 0) ? 1 : 0) + SB;

        logic          rst;
        logic [DW-1:0] tx_data;
        logic          tx_valid;
        logic          tx_ready;
        logic          tx_start;
        logic          tx_done;
        logic          uart_txd;
        logic          busy;
        logic          bps;
        logic          bps_tick;
        logic          spur;

        assign bps = bps_tick | spur;

        uart_tx_frame #(
            .DATA_WIDTH (DW),
            .PARITY_MODE(PM),
            .STOP_BITS  (SB)
        ) dut (
            .clk     (clk),
            .rst     (rst),
            .tx_data (tx_data),
            .tx_valid(tx_valid),
            .tx_ready(tx_ready),
            .tx_start(tx_start),
            .bps_clk (bps),
            .tx_done (tx_done),
            .uart_txd(uart_txd),
            .busy    (busy)
        );

        logic [8:0] exp_q[$];
        bit         active;
        bit         pend;
        int         nticks;
        int         cyc;
        int         done_cyc;

        // Line level after each tick, index 0 = first tick: start, data LSB-first, parity, stops.
        function automatic logic [15:0] frame_bits(input logic [8:0] w);
            logic [15:0] f;
            int ones;
            f    = '1;
            f[0] = 1'b0;
            ones = 0;
            for (int i = 0; i < DW; i++) begin
                f[1 + i] = w[i];
                ones += int'(w[i]);
            end
            if (PM == 1) f[1 + DW] = (ones % 2 == 0);
            else if (PM == 2) f[1 + DW] = (ones % 2 == 1);
            return f;
        endfunction

        initial begin : ticker
            int ph;
            bit run;
            run      = 1'b0;
            ph       = 0;
            bps_tick = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                if (rst || tx_done) run = 1'b0;
                else if (tx_start) begin
                    run = 1'b1;
                    ph  = 0;
                end else if (run) ph++;
                bps_tick = run && (ph % 4 == 3);
            end
        end

        initial begin : mon
            logic [15:0] fb;
            logic        ready_prev;
            logic        txd_prev;
            bit          hs;
            active     = 1'b0;
            pend       = 1'b0;
            nticks     = 0;
            cyc        = 0;
            done_cyc   = -100;
            ready_prev = 1'b0;
            txd_prev   = 1'b1;
            fb         = '1;
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                if (rst) begin
                    check("reset_out", g, {uart_txd, tx_ready, tx_start, tx_done, busy}, 5'b11000);
                    active = 1'b0;
                    pend   = 1'b0;
                    nticks = 0;
                end else begin
                    hs = tx_valid && ready_prev;
                    check("tx_start", g, tx_start, hs);
                    if (hs) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_hs", g, 1, 0);
                            fb = frame_bits('0);
                        end else begin
                            fb = frame_bits(exp_q.pop_front());
                        end
                        pend   = 1'b1;
                        nticks = 0;
                        check("hs_out", g, {busy, tx_ready, uart_txd}, 3'b101);
                    end else if (pend) begin
                        pend   = 1'b0;
                        active = 1'b1;
                        check("arm_out", g, {busy, tx_ready, uart_txd, tx_done}, 4'b1010);
                    end else if (active) begin
                        if (bps) nticks++;
                        check("busy_ready", g, {busy, tx_ready}, 2'b10);
                        check("tx_done", g, tx_done, bps && (nticks == FLEN + 1));
                        if (!bps) check("txd_hold", g, uart_txd, txd_prev);
                        else if (nticks <= FLEN)
                            check($sformatf("frame_bit%0d", nticks), g, uart_txd, fb[nticks-1]);
                        if (tx_done || nticks > FLEN) begin
                            check("stop_line", g, uart_txd, 1);
                            active   = 1'b0;
                            done_cyc = cyc;
                        end
                    end else begin
                        check("idle_out", g, {busy, tx_ready, uart_txd, tx_done}, 4'b0110);
                    end
                end
                ready_prev = tx_ready;
                txd_prev   = uart_txd;
            end
        end

        task automatic send(input logic [8:0] w, input bit hold, input bit arm_spur, input bit gap_chk);
            int t;
            tx_data  = w[DW-1:0];
            tx_valid = 1'b1;
            t = 0;
            while (!tx_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!tx_ready) begin
                check("ready_timeout", g, 0, 1);
                tx_valid = 1'b0;
                return;
            end
            exp_q.push_back(w);
            if (gap_chk) check("b2b_gap", g, cyc + 1 - done_cyc, 2);
            @(negedge clk);
            spur = arm_spur;
            if (!hold) tx_valid = 1'b0;
            @(negedge clk);
            spur = 1'b0;
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            while ((active || pend || exp_q.size() != 0) && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (t >= 400) check("idle_timeout", g, 0, 1);
            repeat (2) @(negedge clk);
        endtask

        initial begin : drv
            int t;
            rst      = 1'b1;
            tx_valid = 1'b0;
            tx_data  = '0;
            spur     = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            send(9'h0A5, 1'b0, 1'b0, 1'b0);
            wait_idle();
            spur = 1'b1;
            @(negedge clk);
            spur = 1'b0;
            @(negedge clk);
            send(9'h007, 1'b0, 1'b1, 1'b0);
            wait_idle();
            send(9'h01F, 1'b0, 1'b0, 1'b0);
            wait_idle();
            send(9'h000, 1'b1, 1'b0, 1'b0);
            send(9'h1FF, 1'b0, 1'b0, 1'b1);
            wait_idle();
            send(9'h05A, 1'b0, 1'b0, 1'b0);
            t = 0;
            while (nticks < 6 && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (t >= 400) check("mid_frame_timeout", g, 0, 1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            send(9'h03C, 1'b0, 1'b0, 1'b0);
            wait_idle();
            repeat (8) begin
                send(9'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
                wait_idle();
            end
            n_fin++;
        end
    end

    initial begin : finish_ctl
        for (int t = 0; t < 40000 && n_fin < NI; t++) @(posedge clk);
        if (n_fin < NI) check("global_timeout", -1, n_fin, NI);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
